// File: rtl/skew_delay_bank.sv
// ---------------------------------------------------------------------------
// skew_delay_bank
//
// Multi-lane shift-register delay bank with a staggered per-lane depth. Lane k
// is BASE_DEPTH + k*SKEW stages deep (or the mirrored ordering when REVERSE=1).
// It is used to skew operand rows into a systolic array and to de-skew result
// rows coming out of it. Every stage carries BITS of data plus a valid bit, and
// a registered counter tracks how many valid tokens are held across the bank.
//
// Ports:
//   clk       in   1            clock, all state changes on the rising edge
//   rst_n     in   1            synchronous active-low reset
//   en        in   1            shift enable; low holds all state
//   flush     in   1            synchronous clear of all stages, beats en
//   d         in   LANES*BITS   input data, lane k at [k*BITS +: BITS]
//   d_valid   in   LANES        per-lane input valid
//   q         out  LANES*BITS   last-stage data of each lane, same packing as d
//   q_valid   out  LANES        last-stage valid of each lane
//   inflight  out  CW           number of valid tokens held in the bank
//   busy      out  1            inflight != 0
// ---------------------------------------------------------------------------
module skew_delay_bank #(
    parameter int LANES      = 8,
    parameter int BITS       = 64,
    parameter int BASE_DEPTH = 1,
    parameter int SKEW       = 1,
    parameter int REVERSE    = 0,
    // Sum of all lane depths; identical for both orderings.
    localparam int TOTAL     = LANES * BASE_DEPTH + (SKEW * LANES * (LANES - 1)) / 2,
    localparam int CW        = $clog2(TOTAL + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [LANES*BITS-1:0]   d,
    input  logic [LANES-1:0]        d_valid,
    output logic [LANES*BITS-1:0]   q,
    output logic [LANES-1:0]        q_valid,
    output logic [CW-1:0]           inflight,
    output logic                    busy
);

    generate
        if (BASE_DEPTH < 1) begin : g_bad_base_depth
            $error("skew_delay_bank: BASE_DEPTH must be at least 1");
        end
    endgenerate

    // Valid bit of the output stage of every lane; these are the tokens that
    // leave the bank on the next enabled shift.
    logic [LANES-1:0] lane_out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int DEPTH = BASE_DEPTH + ((REVERSE != 0) ? (LANES - 1 - gi) : gi) * SKEW;

            logic [BITS-1:0]  data_q [DEPTH];
            logic [BITS-1:0]  data_d [DEPTH];
            logic [DEPTH-1:0] valid_q;
            logic [DEPTH-1:0] valid_d;

            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (flush) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_d[i] = '0;
                    end
                    valid_d = '0;
                end else if (en) begin
                    data_d[0]  = d[gi*BITS +: BITS];
                    valid_d[0] = d_valid[gi];
                    for (int i = 1; i < DEPTH; i++) begin
                        data_d[i]  = data_q[i-1];
                        valid_d[i] = valid_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                    valid_q <= '0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            // Outputs come straight from the last stage register.
            assign q[gi*BITS +: BITS] = data_q[DEPTH-1];
            assign q_valid[gi]        = valid_q[DEPTH-1];
            assign lane_out_valid[gi] = valid_q[DEPTH-1];
        end
    endgenerate

    // In-flight token counter. Tokens entering and leaving on the same shift
    // cancel; the true count always lies in [0, TOTAL], so CW-bit modular
    // arithmetic gives the exact result even when the intermediate wraps.
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;

    always_comb begin
        in_cnt  = '0;
        out_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            in_cnt  = in_cnt  + CW'(d_valid[k]);
            out_cnt = out_cnt + CW'(lane_out_valid[k]);
        end
        inflight_d = inflight_q;
        if (flush) begin
            inflight_d = '0;
        end else if (en) begin
            inflight_d = inflight_q + in_cnt - out_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_skew_delay_bank.sv
// ---------------------------------------------------------------------------
// tb_skew_delay_bank
//
// Directed bench for skew_delay_bank with LANES=4, BITS=8, BASE_DEPTH=1,
// SKEW=1. Two instances share the same stimulus: dut (REVERSE=0, lane depths
// 1,2,3,4) and dut_rev (REVERSE=1, lane depths 4,3,2,1). Inputs change 1ns
// after a rising edge; outputs are sampled at the same point, so each check
// reflects the state after the edge just taken.
// ---------------------------------------------------------------------------
module tb_skew_delay_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic [31:0] d;
    logic [3:0]  d_valid;

    logic [31:0] q_f;
    logic [3:0]  qv_f;
    logic [3:0]  inf_f;
    logic        busy_f;

    logic [31:0] q_r;
    logic [3:0]  qv_r;
    logic [3:0]  inf_r;
    logic        busy_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    skew_delay_bank #(
        .LANES(4), .BITS(8), .BASE_DEPTH(1), .SKEW(1), .REVERSE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .d(d), .d_valid(d_valid),
        .q(q_f), .q_valid(qv_f), .inflight(inf_f), .busy(busy_f)
    );

    skew_delay_bank #(
        .LANES(4), .BITS(8), .BASE_DEPTH(1), .SKEW(1), .REVERSE(1)
    ) dut_rev (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .d(d), .d_valid(d_valid),
        .q(q_r), .q_valid(qv_r), .inflight(inf_r), .busy(busy_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        d       = '0;
        d_valid = '0;
        tick();
        rst_n   = 1'b1;
    endtask

    // Reset held for two edges with en=1 and all-ones data.
    task automatic test_reset();
        rst_n   = 1'b0;
        en      = 1'b1;
        flush   = 1'b0;
        d       = 32'hFFFF_FFFF;
        d_valid = 4'hF;
        tick();
        tick();
        n_checks++;
        if (q_f !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_q: got %h expected %h", q_f, 32'h0);
        end
        n_checks++;
        if (qv_f !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_q_valid: got %b expected %b", qv_f, 4'h0);
        end
        n_checks++;
        if (inf_f !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_inflight: got %0d expected 0", inf_f);
        end
        n_checks++;
        if (busy_f !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy_f);
        end
        n_checks++;
        if (q_r !== 32'h0 || qv_r !== 4'h0 || inf_r !== 4'd0 || busy_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rev: got q=%h qv=%b inf=%0d busy=%b expected all zero",
                     q_r, qv_r, inf_r, busy_r);
        end
        $display("test_reset: q=%h q_valid=%b inflight=%0d busy=%b", q_f, qv_f, inf_f, busy_f);
        rst_n = 1'b1;
    endtask

    // One full beat, then empty beats carrying raw data A5.
    task automatic test_skew();
        logic [3:0] exp_qv;
        logic [7:0] exp_byte;
        do_reset();
        en      = 1'b1;
        d       = 32'h4433_2211;
        d_valid = 4'hF;
        for (int e = 1; e <= 5; e++) begin
            tick();
            d       = 32'hA5A5_A5A5;
            d_valid = 4'h0;
            exp_qv  = (e <= 4) ? 4'(1 << (e - 1)) : 4'h0;
            n_checks++;
            if (qv_f !== exp_qv) begin
                n_fail++;
                $display("FAIL skew_q_valid edge %0d: got %b expected %b", e, qv_f, exp_qv);
            end
            n_checks++;
            if (inf_f !== 4'(5 - e)) begin
                n_fail++;
                $display("FAIL skew_inflight edge %0d: got %0d expected %0d", e, inf_f, 5 - e);
            end
            if (e <= 4) begin
                exp_byte = 8'(8'h11 * e);
                n_checks++;
                if (q_f[(e-1)*8 +: 8] !== exp_byte) begin
                    n_fail++;
                    $display("FAIL skew_data edge %0d lane %0d: got %h expected %h",
                             e, e - 1, q_f[(e-1)*8 +: 8], exp_byte);
                end
            end
            $display("test_skew edge %0d: q=%h q_valid=%b inflight=%0d", e, q_f, qv_f, inf_f);
        end
        // Invalid data still shifts through: lane 0 shows the A5 filler.
        n_checks++;
        if (q_f[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL skew_raw_data: got %h expected a5", q_f[7:0]);
        end
        n_checks++;
        if (busy_f !== 1'b0) begin
            n_fail++;
            $display("FAIL skew_busy_end: got %b expected 0", busy_f);
        end
    endtask

    // Mirrored ordering: lane 3 first, lane 0 last.
    task automatic test_reverse();
        logic [3:0] exp_qv;
        logic [7:0] exp_byte;
        do_reset();
        en      = 1'b1;
        d       = 32'h4433_2211;
        d_valid = 4'hF;
        for (int e = 1; e <= 5; e++) begin
            tick();
            d       = 32'h0;
            d_valid = 4'h0;
            exp_qv  = (e <= 4) ? (4'b1000 >> (e - 1)) : 4'h0;
            n_checks++;
            if (qv_r !== exp_qv) begin
                n_fail++;
                $display("FAIL reverse_q_valid edge %0d: got %b expected %b", e, qv_r, exp_qv);
            end
            n_checks++;
            if (inf_r !== 4'(5 - e)) begin
                n_fail++;
                $display("FAIL reverse_inflight edge %0d: got %0d expected %0d", e, inf_r, 5 - e);
            end
            if (e <= 4) begin
                exp_byte = 8'(8'h11 * (5 - e));
                n_checks++;
                if (q_r[(4-e)*8 +: 8] !== exp_byte) begin
                    n_fail++;
                    $display("FAIL reverse_data edge %0d lane %0d: got %h expected %h",
                             e, 4 - e, q_r[(4-e)*8 +: 8], exp_byte);
                end
            end
            $display("test_reverse edge %0d: q=%h q_valid=%b inflight=%0d", e, q_r, qv_r, inf_r);
        end
    endtask

    // en dropped for three cycles after the first beat.
    task automatic test_hold();
        do_reset();
        en      = 1'b1;
        d       = 32'h4433_2211;
        d_valid = 4'hF;
        tick();
        en      = 1'b0;
        d       = 32'hFFFF_FFFF;
        d_valid = 4'hF;
        for (int e = 2; e <= 4; e++) begin
            tick();
            n_checks++;
            if (qv_f !== 4'b0001 || q_f[7:0] !== 8'h11 || inf_f !== 4'd4 || busy_f !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_frozen edge %0d: got qv=%b lane0=%h inf=%0d busy=%b expected qv=0001 lane0=11 inf=4 busy=1",
                         e, qv_f, q_f[7:0], inf_f, busy_f);
            end
            $display("test_hold edge %0d (en=0): q=%h q_valid=%b inflight=%0d", e, q_f, qv_f, inf_f);
        end
        en      = 1'b1;
        d       = 32'h0;
        d_valid = 4'h0;
        for (int m = 2; m <= 4; m++) begin
            tick();
            n_checks++;
            if (qv_f !== 4'(1 << (m - 1)) || q_f[(m-1)*8 +: 8] !== 8'(8'h11 * m) ||
                inf_f !== 4'(5 - m)) begin
                n_fail++;
                $display("FAIL hold_resume edge %0d: got qv=%b lane=%h inf=%0d expected qv=%b lane=%h inf=%0d",
                         m + 3, qv_f, q_f[(m-1)*8 +: 8], inf_f, 4'(1 << (m - 1)), 8'(8'h11 * m), 5 - m);
            end
            $display("test_hold edge %0d (en=1): q=%h q_valid=%b inflight=%0d", m + 3, q_f, qv_f, inf_f);
        end
    endtask

    // Flush at edge 2 with a full input beat presented.
    task automatic test_flush();
        do_reset();
        en      = 1'b1;
        d       = 32'h4433_2211;
        d_valid = 4'hF;
        tick();
        flush   = 1'b1;
        d       = 32'h9999_9999;
        d_valid = 4'hF;
        tick();
        flush   = 1'b0;
        d_valid = 4'h0;
        d       = 32'h0;
        n_checks++;
        if (qv_f !== 4'h0 || inf_f !== 4'd0 || q_f !== 32'h0 || busy_f !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got qv=%b inf=%0d q=%h busy=%b expected all zero",
                     qv_f, inf_f, q_f, busy_f);
        end
        n_checks++;
        if (qv_r !== 4'h0 || inf_r !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_clear_rev: got qv=%b inf=%0d expected 0 0", qv_r, inf_r);
        end
        $display("test_flush edge 2: q=%h q_valid=%b inflight=%0d", q_f, qv_f, inf_f);
        for (int e = 3; e <= 7; e++) begin
            tick();
            n_checks++;
            if (qv_f !== 4'h0 || qv_r !== 4'h0 || inf_f !== 4'd0 || inf_r !== 4'd0) begin
                n_fail++;
                $display("FAIL flush_no_token edge %0d: got qv=%b qv_rev=%b inf=%0d inf_rev=%0d expected zeros",
                         e, qv_f, qv_r, inf_f, inf_r);
            end
            $display("test_flush edge %0d: q_valid=%b inflight=%0d", e, qv_f, inf_f);
        end
    endtask

    // Ten full beats then four empty ones. Beat b carries 16*k+b on lane k.
    // Lane k (depth k+1) holds beats n-k..n after edge n, restricted to 1..10,
    // and shows beat n-k on its output.
    task automatic test_stream();
        int         b;
        int         exp_inf;
        logic [3:0] exp_qv;
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            if (n <= 10) begin
                for (int k = 0; k < 4; k++) begin
                    d[k*8 +: 8] = 8'(16 * k + n);
                end
                d_valid = 4'hF;
            end else begin
                d       = 32'h0;
                d_valid = 4'h0;
            end
            tick();
            exp_inf = 0;
            for (int k = 0; k < 4; k++) begin
                for (int j = n - k; j <= n; j++) begin
                    if (j >= 1 && j <= 10) exp_inf++;
                end
            end
            n_checks++;
            if (inf_f !== 4'(exp_inf)) begin
                n_fail++;
                $display("FAIL stream_inflight edge %0d: got %0d expected %0d", n, inf_f, exp_inf);
            end
            for (int k = 0; k < 4; k++) begin
                b         = n - k;
                exp_qv[k] = (b >= 1 && b <= 10);
                if (exp_qv[k]) begin
                    n_checks++;
                    if (q_f[k*8 +: 8] !== 8'(16 * k + b)) begin
                        n_fail++;
                        $display("FAIL stream_data edge %0d lane %0d: got %h expected %h",
                                 n, k, q_f[k*8 +: 8], 8'(16 * k + b));
                    end
                end
            end
            n_checks++;
            if (qv_f !== exp_qv) begin
                n_fail++;
                $display("FAIL stream_q_valid edge %0d: got %b expected %b", n, qv_f, exp_qv);
            end
            $display("test_stream edge %0d: q=%h q_valid=%b inflight=%0d", n, q_f, qv_f, inf_f);
        end
    endtask

    // Reset with tokens in flight: nothing drains afterwards.
    task automatic test_reset_midstream();
        do_reset();
        en      = 1'b1;
        d       = 32'h7766_5544;
        d_valid = 4'hF;
        tick();
        tick();
        rst_n = 1'b0;
        flush = 1'b1;
        tick();
        rst_n   = 1'b1;
        flush   = 1'b0;
        d_valid = 4'h0;
        d       = 32'h0;
        n_checks++;
        if (inf_f !== 4'd0 || qv_f !== 4'h0 || q_f !== 32'h0 || inf_r !== 4'd0) begin
            n_fail++;
            $display("FAIL midreset_clear: got inf=%0d qv=%b q=%h inf_rev=%0d expected zeros",
                     inf_f, qv_f, q_f, inf_r);
        end
        for (int e = 1; e <= 4; e++) begin
            tick();
            n_checks++;
            if (qv_f !== 4'h0 || qv_r !== 4'h0 || busy_f !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_no_drain edge %0d: got qv=%b qv_rev=%b busy=%b expected 0 0 0",
                         e, qv_f, qv_r, busy_f);
            end
            $display("test_reset_midstream edge %0d: q_valid=%b inflight=%0d", e, qv_f, inf_f);
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_reverse();
        test_hold();
        test_flush();
        test_stream();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
